// File: rtl/abp_frame_receiver.sv
// Receive end of the alternating-bit protocol: filters duplicate/corrupt frames,
// buffers accepted payloads in a FWFT FIFO and acknowledges every frame.
module abp_frame_receiver #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ACK_RETX   = 15
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          msg_valid,
    input  logic                          msg_bit,
    input  logic                          msg_err,
    input  logic [DATA_W-1:0]             msg_data,
    output logic                          ack_valid,
    output logic                          ack_bit,
    output logic                          out_valid,
    output logic [DATA_W-1:0]             out_data,
    input  logic                          out_ready,
    output logic                          exp_bit,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [7:0]                    drop_cnt
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned TMR_W = $clog2(ACK_RETX + 1);

    typedef enum logic {
        ST_WAIT = 1'b0,
        ST_ACK  = 1'b1
    } state_t;

    state_t             state, state_d;
    logic               exp_bit_d;
    logic               ack_bit_d;
    logic [PTR_W-1:0]   wr_ptr, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr, rd_ptr_d;
    logic [CNT_W-1:0]   count_d;
    logic [7:0]         drop_d;
    logic [TMR_W-1:0]   timer, timer_d;
    logic [DATA_W-1:0]  mem [FIFO_DEPTH];

    logic full, seq_ok, accept, refuse, pop, expire;

    // Frame classification uses pre-update state; full is sampled before any same-cycle pop.
    always_comb begin
        full   = (fifo_count == CNT_W'(FIFO_DEPTH));
        seq_ok = msg_valid && !msg_err && (msg_bit == exp_bit);
        accept = seq_ok && !full;
        refuse = seq_ok && full;
        pop    = out_valid && out_ready;
        expire = !msg_valid && (timer == TMR_W'(ACK_RETX));
    end

    // Next-state: every frame or timer expiry produces exactly one ack pulse.
    always_comb begin
        state_d   = ST_WAIT;
        exp_bit_d = exp_bit;
        ack_bit_d = ack_bit;
        wr_ptr_d  = wr_ptr;
        rd_ptr_d  = rd_ptr;
        count_d   = fifo_count;
        drop_d    = drop_cnt;
        timer_d   = timer + TMR_W'(1);

        if (accept) begin
            exp_bit_d = ~exp_bit;
            wr_ptr_d  = wr_ptr + PTR_W'(1);
        end
        if (refuse && (drop_cnt != 8'hFF)) begin
            drop_d = drop_cnt + 8'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr + PTR_W'(1);
        end
        count_d = fifo_count + CNT_W'(accept) - CNT_W'(pop);

        if (msg_valid || expire) begin
            state_d   = ST_ACK;
            ack_bit_d = ~exp_bit_d;
            timer_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_WAIT;
            exp_bit    <= 1'b0;
            ack_bit    <= 1'b1;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            drop_cnt   <= '0;
            timer      <= '0;
        end else begin
            state      <= state_d;
            exp_bit    <= exp_bit_d;
            ack_bit    <= ack_bit_d;
            wr_ptr     <= wr_ptr_d;
            rd_ptr     <= rd_ptr_d;
            fifo_count <= count_d;
            drop_cnt   <= drop_d;
            timer      <= timer_d;
        end
    end

    // Payload storage needs no reset; out_data is forced to zero while empty.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= msg_data;
        end
    end

    assign ack_valid = (state == ST_ACK);
    assign out_valid = (fifo_count != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_abp_frame_receiver.sv
// Bench for abp_frame_receiver: directed protocol scenarios plus random traffic
// compared against a queue-based model of the receiver.
module tb_abp_frame_receiver;

    localparam int unsigned DATA_W     = 8;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned ACK_RETX   = 15;
    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned VEC_W      = 3 + DATA_W + CNT_W + 1 + 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              msg_valid = 1'b0, msg_bit = 1'b0, msg_err = 1'b0;
    logic [DATA_W-1:0] msg_data = '0;
    logic              out_ready = 1'b0;
    logic              ack_valid, ack_bit, out_valid, exp_bit;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  fifo_count;
    logic [7:0]        drop_cnt;

    abp_frame_receiver #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .ACK_RETX(ACK_RETX)) dut (
        .clk(clk), .rst_n(rst_n), .msg_valid(msg_valid), .msg_bit(msg_bit),
        .msg_err(msg_err), .msg_data(msg_data), .ack_valid(ack_valid), .ack_bit(ack_bit),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .exp_bit(exp_bit), .fifo_count(fifo_count), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: payload queue, expected bit, drop count, last ack issue edge.
    logic [DATA_W-1:0] m_q[$];
    logic m_exp, m_ack_v, m_ack_bit;
    int   m_drop, m_edge, m_last;
    int   n_checks = 0, n_errors = 0;

    function automatic logic [VEC_W-1:0] expect_vec();
        logic [DATA_W-1:0] head;
        head = (m_q.size() > 0) ? m_q[0] : '0;
        return {m_ack_v, m_ack_bit, (m_q.size() > 0), head, CNT_W'(m_q.size()), m_exp, 8'(m_drop)};
    endfunction

    function automatic logic [VEC_W-1:0] dut_vec();
        return {ack_valid, ack_bit, out_valid, out_data, fifo_count, exp_bit, drop_cnt};
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_exp = 1'b0; m_ack_v = 1'b0; m_ack_bit = 1'b1; m_drop = 0; m_last = m_edge;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        msg_valid = 1'b0; msg_bit = 1'b0; msg_err = 1'b0; msg_data = '0; out_ready = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drive one cycle, advance the model across the edge, return just after the edge.
    task automatic drive_cycle(input logic v, input logic b, input logic e,
                               input logic [DATA_W-1:0] d, input logic r);
        logic pop, full;
        msg_valid = v; msg_bit = b; msg_err = e; msg_data = d; out_ready = r;
        pop  = (m_q.size() > 0) && r;
        full = (m_q.size() == FIFO_DEPTH);
        m_edge++;
        if (v && !e && (b == m_exp)) begin
            if (!full) begin
                m_q.push_back(d);
                m_exp = ~m_exp;
            end else if (m_drop < 255) begin
                m_drop++;
            end
        end
        if (pop) void'(m_q.pop_front());
        if (v || (m_edge - m_last == int'(ACK_RETX) + 1)) begin
            m_ack_v = 1'b1; m_ack_bit = ~m_exp; m_last = m_edge;
        end else begin
            m_ack_v = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 1'b0, '0, r);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({ack_valid, ack_bit, out_valid, out_data, fifo_count, exp_bit, drop_cnt} !==
            {1'b0, 1'b1, 1'b0, DATA_W'(0), CNT_W'(0), 1'b0, 8'd0}) begin
            n_errors++;
            $display("FAIL reset_values got=%h want=%h", dut_vec(), expect_vec());
        end
    endtask

    task automatic test_basic();
        do_reset();
        drive_cycle(1'b1, 1'b0, 1'b0, 8'hA5, 1'b0);
        n_checks++;
        if (ack_valid !== 1'b1 || ack_bit !== 1'b0 || out_data !== 8'hA5) begin
            n_errors++;
            $display("FAIL basic_ack0 got v=%b b=%b d=%h want v=1 b=0 d=a5", ack_valid, ack_bit, out_data);
        end
        idle(2, 1'b0);
        n_checks++;
        if (dut_vec() !== expect_vec()) begin
            n_errors++;
            $display("FAIL basic_gap got=%h want=%h", dut_vec(), expect_vec());
        end
        drive_cycle(1'b1, 1'b1, 1'b0, 8'h3C, 1'b0);
        n_checks++;
        if (ack_valid !== 1'b1 || ack_bit !== 1'b1 || fifo_count !== CNT_W'(2)) begin
            n_errors++;
            $display("FAIL basic_ack1 got v=%b b=%b cnt=%0d want v=1 b=1 cnt=2", ack_valid, ack_bit, fifo_count);
        end
        idle(1, 1'b1);
        n_checks++;
        if (out_data !== 8'h3C || exp_bit !== 1'b0 || fifo_count !== CNT_W'(1)) begin
            n_errors++;
            $display("FAIL basic_pop got d=%h exp=%b cnt=%0d want d=3c exp=0 cnt=1", out_data, exp_bit, fifo_count);
        end
    endtask

    task automatic test_duplicate();
        logic [2:0] acks;
        do_reset();
        drive_cycle(1'b1, 1'b0, 1'b0, 8'h11, 1'b0); acks[2] = ack_bit;
        drive_cycle(1'b1, 1'b0, 1'b0, 8'h11, 1'b0); acks[1] = ack_bit;
        drive_cycle(1'b1, 1'b1, 1'b0, 8'h22, 1'b0); acks[0] = ack_bit;
        n_checks++;
        if (acks !== 3'b001 || fifo_count !== CNT_W'(2) || out_data !== 8'h11) begin
            n_errors++;
            $display("FAIL dup_filter got acks=%b cnt=%0d d=%h want acks=001 cnt=2 d=11", acks, fifo_count, out_data);
        end
        idle(1, 1'b1);
        n_checks++;
        if (out_data !== 8'h22 || fifo_count !== CNT_W'(1)) begin
            n_errors++;
            $display("FAIL dup_second got d=%h cnt=%0d want d=22 cnt=1", out_data, fifo_count);
        end
    endtask

    task automatic test_corrupt();
        do_reset();
        drive_cycle(1'b1, 1'b0, 1'b1, DATA_W'($urandom), 1'b0);
        n_checks++;
        if (ack_valid !== 1'b1 || ack_bit !== 1'b1 || fifo_count !== CNT_W'(0) || out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL corrupt_drop got v=%b b=%b cnt=%0d want v=1 b=1 cnt=0", ack_valid, ack_bit, fifo_count);
        end
        drive_cycle(1'b1, 1'b0, 1'b0, 8'h55, 1'b0);
        n_checks++;
        if (ack_bit !== 1'b0 || fifo_count !== CNT_W'(1) || out_data !== 8'h55) begin
            n_errors++;
            $display("FAIL corrupt_recover got b=%b cnt=%0d d=%h want b=0 cnt=1 d=55", ack_bit, fifo_count, out_data);
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 5; i++) drive_cycle(1'b1, 1'(i % 2), 1'b0, 8'(8'h40 + i), 1'b0);
        n_checks++;
        if (ack_bit !== 1'b1 || drop_cnt !== 8'd1 || fifo_count !== CNT_W'(4) || exp_bit !== 1'b0) begin
            n_errors++;
            $display("FAIL full_refuse got b=%b drop=%0d cnt=%0d exp=%b want b=1 drop=1 cnt=4 exp=0",
                     ack_bit, drop_cnt, fifo_count, exp_bit);
        end
        idle(1, 1'b1);
        drive_cycle(1'b1, 1'b0, 1'b0, 8'h44, 1'b0);
        n_checks++;
        if (ack_bit !== 1'b0 || fifo_count !== CNT_W'(4) || out_data !== 8'h41) begin
            n_errors++;
            $display("FAIL full_resend got b=%b cnt=%0d d=%h want b=0 cnt=4 d=41", ack_bit, fifo_count, out_data);
        end
        // Push and pop together while full: push refused, pop still happens.
        drive_cycle(1'b1, 1'b1, 1'b0, 8'h99, 1'b1);
        n_checks++;
        if (dut_vec() !== expect_vec() || drop_cnt !== 8'd2 || fifo_count !== CNT_W'(3)) begin
            n_errors++;
            $display("FAIL full_push_pop got=%h want=%h", dut_vec(), expect_vec());
        end
    endtask

    task automatic test_timeout();
        logic want;
        do_reset();
        for (int k = 1; k <= 40; k++) begin
            idle(1, 1'b0);
            want = (k == 16) || (k == 32);
            n_checks++;
            if (ack_valid !== want || (want && ack_bit !== 1'b1)) begin
                n_errors++;
                $display("FAIL timeout_cyc%0d got v=%b b=%b want v=%b b=1", k, ack_valid, ack_bit, want);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'(i % 2), 1'b0, 8'(8'h70 + i), 1'b0);
        n_checks++;
        if (ack_valid !== 1'b1 || fifo_count !== CNT_W'(3)) begin
            n_errors++;
            $display("FAIL async_setup got v=%b cnt=%0d want v=1 cnt=3", ack_valid, fifo_count);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({ack_valid, ack_bit, out_valid, out_data, fifo_count, exp_bit, drop_cnt} !==
            {1'b0, 1'b1, 1'b0, DATA_W'(0), CNT_W'(0), 1'b0, 8'd0}) begin
            n_errors++;
            $display("FAIL async_reset got v=%b b=%b ov=%b d=%h cnt=%0d exp=%b drop=%0d want 0 1 0 00 0 0 0",
                     ack_valid, ack_bit, out_valid, out_data, fifo_count, exp_bit, drop_cnt);
        end
        @(negedge clk);
        do_reset();
    endtask

    task automatic test_random();
        logic v, b, e, r;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            // Alternate dense traffic with sparse phases that let the retransmit timer fire.
            v = ((i / 100) % 2 == 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 24) == 0);
            b = ($urandom_range(0, 3) == 0) ? ~m_exp : m_exp;
            e = ($urandom_range(0, 5) == 0);
            r = ($urandom_range(0, 2) == 0);
            drive_cycle(v, b, e, DATA_W'($urandom), r);
            n_checks++;
            if (dut_vec() !== expect_vec()) begin
                n_errors++;
                $display("FAIL random_cyc%0d got=%h want=%h", i, dut_vec(), expect_vec());
            end
        end
    endtask

    initial begin
        m_edge = 0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_basic();
        test_duplicate();
        test_corrupt();
        test_full();
        test_timeout();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
